// File: rtl/memsync_axi_arbiter_pkg.sv
// memsync_pkg: sync FSM states, fixed AXI field values and the round-robin pick helper
package memsync_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} sync_state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEF = 4'b0011;
  localparam int RR_MAX = 64;
  // Index of the first set bit at or after ptr, wrapping modulo n; -1 when mask is empty
  function automatic int rr_first(input logic [RR_MAX-1:0] mask, input int ptr, input int n);
    int j;
    rr_first = -1;
    for (int k = RR_MAX - 1; k >= 0; k--) begin
      j = (ptr + k) % n;
      if (k < n && j < RR_MAX && mask[j[5:0]]) rr_first = j;
    end
  endfunction
endpackage

// File: rtl/memsync_axi_arbiter_if.sv
// memsync_axi_arbiter_if: AXI4 port shared by the MEMSync engines, master/slave views
interface memsync_axi_arbiter_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int AXI_ID_WIDTH = 8
);
  logic [AXI_ID_WIDTH-1:0] awid, arid, bid, rid;
  logic [AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [3:0] awcache, arcache;
  logic awlock, arlock, awvalid, awready, arvalid, arready;
  logic [AXI_DATA_WIDTH-1:0] wdata, rdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;
  modport master(
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave(
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input wdata, wstrb, wlast, wvalid, bready,
    input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/memsync_axi_arbiter_rr_picker.sv
// rr_picker: first requester at or after the pointer (wrapping), as one-hot and index
module rr_picker import memsync_pkg::*; #(
  parameter int NREQ = 16,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] mask_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);
  int sel;
  assign sel = rr_first(RR_MAX'(mask_i), int'(ptr_i), NREQ);
  assign any_o = sel >= 0;
  assign idx_o = IW'(sel);
  assign onehot_o = any_o ? NREQ'(1) << idx_o : '0;
endmodule

// File: rtl/memsync_axi_arbiter.sv
// memsync_axi_arbiter: round-robin owner of the DIMM AXI port for MEMSync bursts; MEMSYNC_WB_PRIORITY_EN favours writebacks
module memsync_axi_arbiter import memsync_pkg::*; #(
  parameter int NREQ = 16,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int AXI_ID_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NREQ-1:0]                  req_valid,
  input  logic [NREQ-1:0]                  req_wr,
  input  logic [NREQ*AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NREQ*8-1:0]                req_len,
  output logic [NREQ-1:0]                  grant,
  input  logic [NREQ*AXI_DATA_WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]                  wbeat,
  output logic [AXI_DATA_WIDTH-1:0]        rdata,
  output logic [NREQ-1:0]                  rbeat,
  output logic [NREQ-1:0]                  done,
  output logic                             err,
  output logic                             stall,
  memsync_axi_arbiter_if.master            m_axi
);
  localparam int IW = $clog2(NREQ);
  localparam logic [2:0] AXI_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));
  sync_state_t state_q, state_d;
  logic [NREQ-1:0] own_q, own_d, mask, pick_oh;
  logic [IW-1:0] idx_q, idx_d, rr_q, rr_d, pick_idx;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0] len_q, len_d, beat_q, beat_d;
  logic wr_q, wr_d, err_q, err_d, pick_any, unused_ids;
`ifdef MEMSYNC_WB_PRIORITY_EN
  assign mask = |(req_valid & req_wr) ? req_valid & req_wr : req_valid;
`else
  assign mask = req_valid;
`endif
  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .mask_i(mask), .ptr_i(rr_q), .onehot_o(pick_oh), .idx_o(pick_idx), .any_o(pick_any)
  );
  always_comb begin
    state_d = state_q;
    own_d = own_q;
    idx_d = idx_q;
    rr_d = rr_q;
    wr_d = wr_q;
    addr_d = addr_q;
    len_d = len_q;
    beat_d = beat_q;
    err_d = err_q | (m_axi.bvalid & m_axi.bready & |m_axi.bresp)
                  | (m_axi.rvalid & m_axi.rready & |m_axi.rresp);
    case (state_q)
      IDLE: if (pick_any) begin
        state_d = ADDR;
        own_d = pick_oh;
        idx_d = pick_idx;
        wr_d = |(req_wr & pick_oh);
        addr_d = req_addr[pick_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        len_d = req_len[pick_idx*8 +: 8];
        beat_d = '0;
      end
      ADDR: state_d = (wr_q ? m_axi.awready : m_axi.arready) ? DATA : ADDR;
      DATA: if (wr_q && m_axi.wready) begin
        beat_d = beat_q + 8'd1;
        state_d = beat_q == len_q ? RESP : DATA;
      end else if (!wr_q && m_axi.rvalid && m_axi.rlast) state_d = DONE;
      RESP: state_d = m_axi.bvalid ? DONE : RESP;
      DONE: begin
        state_d = IDLE;
        own_d = '0;
        rr_d = idx_q == IW'(NREQ - 1) ? '0 : idx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      own_q <= '0;
      idx_q <= '0;
      rr_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      len_q <= '0;
      beat_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      idx_q <= idx_d;
      rr_q <= rr_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      len_q <= len_d;
      beat_q <= beat_d;
      err_q <= err_d;
    end
  end
  assign grant = state_q == DONE ? '0 : own_q;
  assign done = state_q == DONE ? own_q : '0;
  assign wbeat = (state_q == DATA && wr_q && m_axi.wready) ? own_q : '0;
  assign rbeat = (state_q == DATA && !wr_q && m_axi.rvalid) ? own_q : '0;
  assign rdata = m_axi.rdata;
  assign err = err_q;
  assign stall = |req_valid | (state_q != IDLE);
  assign unused_ids = ^{m_axi.bid, m_axi.rid};
  assign m_axi.awid = AXI_ID_WIDTH'(idx_q);
  assign m_axi.arid = AXI_ID_WIDTH'(idx_q);
  assign m_axi.awaddr = addr_q;
  assign m_axi.araddr = addr_q;
  assign m_axi.awlen = len_q;
  assign m_axi.arlen = len_q;
  assign m_axi.awsize = AXI_SIZE;
  assign m_axi.arsize = AXI_SIZE;
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.awlock = 1'b0;
  assign m_axi.arlock = 1'b0;
  assign m_axi.awcache = AXI_CACHE_DEF;
  assign m_axi.arcache = AXI_CACHE_DEF;
  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;
  assign m_axi.awvalid = state_q == ADDR && wr_q;
  assign m_axi.arvalid = state_q == ADDR && !wr_q;
  assign m_axi.wvalid = state_q == DATA && wr_q;
  assign m_axi.wdata = wdata[idx_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign m_axi.wstrb = '1;
  assign m_axi.wlast = beat_q == len_q;
  assign m_axi.rready = state_q == DATA && !wr_q;
  assign m_axi.bready = state_q == RESP;
endmodule
